// File: rtl/sm4_encryptor_pkg.sv
// sm4_encryptor_pkg: SM4 constants (S-box, CK, FK), sizes and engine state type
package sm4_encryptor_pkg;
  localparam int group_size_p = 128;
  localparam int word_width_p = 32;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  localparam logic [127:0] fk_c = 128'ha3b1bac6_56aa3350_677d9197_b27022dc;
  localparam logic [31:0] ck_c [32] = '{
    32'h00070e15, 32'h1c232a31, 32'h383f464d, 32'h545b6269,
    32'h70777e85, 32'h8c939aa1, 32'ha8afb6bd, 32'hc4cbd2d9,
    32'he0e7eef5, 32'hfc030a11, 32'h181f262d, 32'h343b4249,
    32'h50575e65, 32'h6c737a81, 32'h888f969d, 32'ha4abb2b9,
    32'hc0c7ced5, 32'hdce3eaf1, 32'hf8ff060d, 32'h141b2229,
    32'h30373e45, 32'h4c535a61, 32'h686f767d, 32'h848b9299,
    32'ha0a7aeb5, 32'hbcc3cad1, 32'hd8dfe6ed, 32'hf4fb0209,
    32'h10171e25, 32'h2c333a41, 32'h484f565d, 32'h646b7279};
  localparam logic [7:0] sbox_c [256] = '{
    8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
    8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
    8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
    8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
    8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
    8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
    8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
    8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
    8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
    8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
    8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
    8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
    8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
    8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
    8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
    8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48};
endpackage

// File: rtl/turn_transform.sv
// turn_transform: one SM4 round word, X0 ^ T(X1^X2^X3^rk), cipher or key-schedule linear layer
module turn_transform
  import sm4_encryptor_pkg::*;
(
  input  logic [group_size_p-1:0] x_i,
  input  logic [word_width_p-1:0] rk_i,
  input  logic                    is_key_i,
  input  logic [word_width_p-1:0] mask_i,
  input  logic [word_width_p-1:0] dismask_i,
  output logic [word_width_p-1:0] word_o
);
  logic [31:0] t, b, l;
  // nonlinear tau then the mode-selected linear diffusion L or L'
  always_comb begin
    t = x_i[95:64] ^ x_i[63:32] ^ x_i[31:0] ^ rk_i ^ mask_i;
    b = {sbox_c[t[31:24]], sbox_c[t[23:16]], sbox_c[t[15:8]], sbox_c[t[7:0]]};
    l = is_key_i ? b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]}
                 : b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]} ^ {b[13:0], b[31:14]} ^ {b[7:0], b[31:8]};
    word_o = x_i[127:96] ^ l ^ dismask_i;
  end
endmodule

// File: rtl/sm4_round_engine.sv
// sm4_round_engine: iterative SM4 cipher / key expansion, unroll_p rounds per clock
module sm4_round_engine
  import sm4_encryptor_pkg::*;
#(
  parameter int unroll_p = 1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    v_i,
  output logic                    ready_o,
  input  logic [127:0]            data_i,
  input  logic                    is_key_i,
  input  logic                    decrypt_i,
  output logic [4:0]              rkey_idx_o,
  input  logic [unroll_p*32-1:0]  rkey_i,
  output logic                    rkey_v_o,
  output logic [unroll_p*32-1:0]  rkey_o,
  output logic                    v_o,
  input  logic                    ready_i,
  output logic [127:0]            data_o
);
  if (!(unroll_p == 1 || unroll_p == 2 || unroll_p == 4 || unroll_p == 8)) begin : g_bad_unroll
    $error("unroll_p must be 1, 2, 4 or 8");
  end
  state_e state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [127:0] x_q, x_d;
  logic key_q, key_d, dec_q, dec_d, ready_q, ready_d;
  logic [127:0] x_l [unroll_p+1];
  logic [31:0] w [unroll_p];
  assign x_l[0] = x_q;
  for (genvar j = 0; j < unroll_p; j++) begin : g_lane
    turn_transform u_turn (
      .x_i      (x_l[j]),
      .rk_i     (key_q ? ck_c[cnt_q[4:0] + 5'(j)] : rkey_i[32*j +: 32]),
      .is_key_i (key_q),
      .mask_i   (32'd0),
      .dismask_i(32'd0),
      .word_o   (w[j])
    );
    assign x_l[j+1] = {x_l[j][95:0], w[j]};
    assign rkey_o[32*j +: 32] = w[j];
  end
  assign ready_o = ready_q;
  assign v_o = state_q == DONE;
  assign rkey_v_o = state_q == BUSY && key_q;
  assign rkey_idx_o = state_q != BUSY ? 5'd0 : dec_q && !key_q ? 5'(6'd31 - cnt_q) : cnt_q[4:0];
  assign data_o = {x_q[31:0], x_q[63:32], x_q[95:64], x_q[127:96]};
  // accept in IDLE, iterate rounds in BUSY, hold the result in DONE until taken
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    x_d = x_q;
    key_d = key_q;
    dec_d = dec_q;
    if (state_q == IDLE && ready_q && v_i) begin
      x_d = data_i;
      key_d = is_key_i;
      dec_d = decrypt_i;
      cnt_d = '0;
      state_d = BUSY;
    end else if (state_q == BUSY) begin
      x_d = x_l[unroll_p];
      cnt_d = cnt_q + 6'(unroll_p);
      state_d = cnt_d == 6'd32 ? DONE : BUSY;
    end else if (state_q == DONE && ready_i) begin
      state_d = IDLE;
    end
    ready_d = state_d == IDLE;
  end
  // state registers; reset drops any in-flight group
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q <= '0;
      x_q <= '0;
      key_q <= 1'b0;
      dec_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      x_q <= x_d;
      key_q <= key_d;
      dec_q <= dec_d;
      ready_q <= ready_d;
    end
  end
endmodule

// File: tb/tb_sm4_round_engine.sv
// tb_sm4_round_engine: vectors, corner sequences and random traffic against an SM4 model for unroll 1/2/4/8
module tb_sm4_round_engine;
  import sm4_encryptor_pkg::*;
  localparam logic [127:0] pt_c = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] ct_c = 128'h681edf34d206965e86b3e94f536e4246;
  localparam logic [127:0] fk_tb = 128'ha3b1bac656aa3350677d9197b27022dc;
  logic clk = 0, reset = 1, is_key = 0, decrypt = 0, dec_cur = 0, ready_in = 0;
  logic [127:0] data_in = '0;
  logic [3:0] v_in = '0;
  logic rdy [4], rkv [4], v_out [4];
  logic [4:0] idx [4];
  logic [255:0] rko [4];
  logic [127:0] dout [4];
  logic [31:0] rk_mem [32];
  logic [31:0] m_rk [32];
  int n_vec = 0, n_bad = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int U = 1 << g;
    logic [U*32-1:0] rki, rko_w;
    always_comb begin
      rki = '0;
      for (int j = 0; j < U; j++) rki[32*j +: 32] = rk_mem[dec_cur ? idx[g] - 5'(j) : idx[g] + 5'(j)];
    end
    assign rko[g] = 256'(rko_w);
    sm4_round_engine #(.unroll_p(U)) dut (
      .clk_i(clk), .reset_i(reset), .v_i(v_in[g]), .ready_o(rdy[g]), .data_i(data_in),
      .is_key_i(is_key), .decrypt_i(decrypt), .rkey_idx_o(idx[g]), .rkey_i(rki),
      .rkey_v_o(rkv[g]), .rkey_o(rko_w), .v_o(v_out[g]), .ready_i(ready_in), .data_o(dout[g]));
  end
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction
  function automatic logic [31:0] tf(input logic [31:0] x, input bit key);
    logic [31:0] b = {sbox_c[x[31:24]], sbox_c[x[23:16]], sbox_c[x[15:8]], sbox_c[x[7:0]]};
    return key ? b ^ rol(b, 13) ^ rol(b, 23) : b ^ rol(b, 2) ^ rol(b, 10) ^ rol(b, 18) ^ rol(b, 24);
  endfunction
  function automatic logic [31:0] ck(input int i);
    logic [31:0] c;
    for (int j = 0; j < 4; j++) c[31-8*j -: 8] = 8'((4*i + j) * 7);
    return c;
  endfunction
  task automatic model_keys(input logic [127:0] mkfk);
    logic [31:0] k [36];
    for (int i = 0; i < 4; i++) k[i] = mkfk[127-32*i -: 32];
    for (int i = 0; i < 32; i++) begin
      k[i+4] = k[i] ^ tf(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck(i), 1);
      m_rk[i] = k[i+4];
    end
  endtask
  function automatic logic [127:0] model_crypt(input logic [127:0] d, input bit dec);
    logic [31:0] x [36];
    for (int i = 0; i < 4; i++) x[i] = d[127-32*i -: 32];
    for (int i = 0; i < 32; i++) x[i+4] = x[i] ^ tf(x[i+1] ^ x[i+2] ^ x[i+3] ^ m_rk[dec ? 31 - i : i], 0);
    return {x[35], x[34], x[33], x[32]};
  endfunction
  task automatic run(input int g, input bit k, input bit d, input logic [127:0] din, input int hold,
                     output logic [127:0] res, output int lat);
    int u = 1 << g;
    int busy = 0;
    bit ok = 1;
    @(negedge clk);
    is_key = k; decrypt = d; dec_cur = d && !k; data_in = din; v_in[g] = 1;
    @(posedge clk); #1;
    v_in[g] = 0;
    lat = 1;
    while (!v_out[g] && lat < 100) begin
      if (idx[g] !== (dec_cur ? 5'(31 - busy * u) : 5'(busy * u))) ok = 0;
      if (rkv[g] !== k) ok = 0;
      if (k) for (int j = 0; j < u; j++) rk_mem[(busy * u + j) % 32] = rko[g][32*j +: 32];
      busy++;
      @(posedge clk); #1;
      lat++;
    end
    check("busy_idx_rkv_seq", {127'd0, ok}, 128'd1);
    check("busy_cycles", 128'(busy), 128'(32 / u));
    res = dout[g];
    if (!v_out[g]) return;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      v_in[g] = 1; data_in = ~din;
      @(posedge clk); #1;
      check("hold_vo_ready_data", {v_out[g], rdy[g], dout[g] == res}, {1'b1, 1'b0, 1'b1});
    end
    @(negedge clk);
    v_in[g] = 0; ready_in = 1;
    @(posedge clk); #1;
    ready_in = 0;
    check("handshake_vo_rdy_idx", {v_out[g], rdy[g], idx[g]}, {1'b0, 1'b1, 5'd0});
  endtask
  typedef struct {int g; bit dec; logic [127:0] din; logic [127:0] exp; int lat;} vec_t;
  initial begin
    vec_t tbl [6];
    logic [127:0] res, key, pt;
    int lat, g;
    bit seen;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      check($sformatf("reset_outputs_%0d", i), {v_out[i], rkv[i], rdy[i], idx[i], dout[i]}, '0);
    @(negedge clk); reset = 0;
    @(posedge clk); #1;
    check("ready_after_reset", {rdy[0], rdy[1], rdy[2], rdy[3]}, 4'hf);
    run(0, 1, 0, pt_c ^ fk_tb, 0, res, lat);
    model_keys(pt_c ^ fk_tb);
    check("rk_first", rk_mem[0], 32'hf12186f9);
    check("rk_last", rk_mem[31], 32'h9124a012);
    for (int i = 0; i < 32; i++) check($sformatf("rk_model_%0d", i), rk_mem[i], m_rk[i]);
    check("key_mode_data", res, {m_rk[31], m_rk[30], m_rk[29], m_rk[28]});
    check("key_mode_lat", 128'(lat), 128'd33);
    tbl = '{'{0, 0, pt_c, ct_c, 33}, '{0, 1, ct_c, pt_c, 33}, '{1, 0, pt_c, ct_c, 17},
            '{2, 0, pt_c, ct_c, 9}, '{3, 0, pt_c, ct_c, 5}, '{3, 1, ct_c, pt_c, 5}};
    foreach (tbl[i]) begin
      run(tbl[i].g, 0, tbl[i].dec, tbl[i].din, 0, res, lat);
      check($sformatf("vec%0d_data", i), res, tbl[i].exp);
      check($sformatf("vec%0d_lat", i), 128'(lat), 128'(tbl[i].lat));
    end
    run(0, 0, 0, pt_c, 10, res, lat);
    check("backpressure_data", res, ct_c);
    @(negedge clk);
    is_key = 0; decrypt = 0; dec_cur = 0; data_in = pt_c; v_in[0] = 1;
    @(posedge clk); #1;
    v_in[0] = 0;
    repeat (4) @(posedge clk);
    @(negedge clk); reset = 1;
    @(posedge clk); #1;
    check("reset_busy_outputs", {v_out[0], rkv[0], rdy[0], idx[0]}, '0);
    @(negedge clk); reset = 0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (v_out[0] || rkv[0]) seen = 1;
    end
    check("no_vo_after_reset", {127'd0, seen}, '0);
    run(0, 0, 0, pt_c, 0, res, lat);
    check("after_reset_data", res, ct_c);
    for (int r = 0; r < 6; r++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      pt = {$urandom, $urandom, $urandom, $urandom};
      model_keys(key);
      g = $urandom_range(0, 3);
      run(g, 1, $urandom_range(0, 1), key, 0, res, lat);
      for (int i = 0; i < 32; i++) if (rk_mem[i] !== m_rk[i]) check($sformatf("rnd%0d_rk%0d", r, i), rk_mem[i], m_rk[i]);
      check($sformatf("rnd%0d_keydata", r), res, {m_rk[31], m_rk[30], m_rk[29], m_rk[28]});
      g = $urandom_range(0, 3);
      run(g, 0, 0, pt, 0, res, lat);
      check($sformatf("rnd%0d_enc", r), res, model_crypt(pt, 0));
      check($sformatf("rnd%0d_lat", r), 128'(lat), 128'(32 / (1 << g) + 1));
      g = $urandom_range(0, 3);
      run(g, 0, 1, res, 0, res, lat);
      check($sformatf("rnd%0d_dec", r), res, pt);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
